fetch_pc_sequencer: RTL and testbench

- Owns the fetch program counter and decides each cycle which next-PC source drives the program-memory word address.
- Arbitrates interrupt entry, interrupt return, branch resolution and branch prediction by fixed priority; sequential fetch is the default.
- Holds the PC during stalls and latches at most one redirect that arrives while stalled.
- Runs a small interrupt state machine that saves and restores the interrupted PC; sits between the execute/branch-predict logic and the instruction-fetch stage.

---
 rtl/fetch_pc_sequencer_if.sv | 31 +++
 rtl/fetch_pc_sequencer.sv | 130 +++++++++++++
 tb/tb_fetch_pc_sequencer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pc_sequencer_if.sv
// Fetch PC sequencer bus: groups the redirect, interrupt and fetch-address
// signals exchanged between the execute/predict side and the fetch stage.
//   master : drives stall/redirect/interrupt requests, observes PC outputs
//   slave  : the sequencer itself
interface fetch_pc_sequencer_if;
   logic        stall_in;
   logic        branch_taken_in;
   logic [63:0] branch_pc_in;
   logic        pred_taken_in;
   logic [63:0] pred_pc_in;
   logic        irq_in;
   logic [63:0] irq_vector_in;
   logic        mret_in;
   logic [63:0] pc_out;
   logic [63:0] instr_address_out;
   logic [63:0] epc_out;
   logic        in_handler_out;
   logic        flush_out;

   modport master (
      output stall_in, branch_taken_in, branch_pc_in, pred_taken_in, pred_pc_in,
             irq_in, irq_vector_in, mret_in,
      input  pc_out, instr_address_out, epc_out, in_handler_out, flush_out
   );

   modport slave (
      input  stall_in, branch_taken_in, branch_pc_in, pred_taken_in, pred_pc_in,
             irq_in, irq_vector_in, mret_in,
      output pc_out, instr_address_out, epc_out, in_handler_out, flush_out
   );
endinterface

// File: rtl/fetch_pc_sequencer.sv
// Fetch program-counter sequencer.
// Picks the next fetch PC each cycle by fixed priority: interrupt entry/return,
// execute redirect, pending (stall-captured) redirect, prediction, sequential.
// Holds the PC while stalled and keeps one pending redirect captured during
// the stall. Saves/restores the interrupted PC around a single-level handler.
// Ports:
//   clk_in   : clock, rising edge
//   rst_n_in : asynchronous active-low reset
//   bus      : slave side of fetch_pc_sequencer_if (requests in, PC/epc/flush out)
//
// state   | meaning
// IDLE    | normal fetch, interrupts accepted
// ENTER   | first handler cycle, flush pulse from the vector load
// HANDLER | servicing interrupt, irq ignored, waiting for mret
// RETURN  | first cycle back at the saved PC, flush pulse, no irq accepted yet
module fetch_pc_sequencer #(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter logic [63:0] PC_STEP  = 64'd4
) (
   input logic                   clk_in,
   input logic                   rst_n_in,
   fetch_pc_sequencer_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ENTER   = 2'd1,
      HANDLER = 2'd2,
      RETURN  = 2'd3
   } state_t;

   state_t      state, state_nxt;
   logic [63:0] pc, pc_nxt;
   logic [63:0] epc, epc_nxt;
   logic [63:0] pend_pc, pend_pc_nxt;
   logic        pend_vld, pend_vld_nxt;
   logic        pend_br, pend_br_nxt;
   logic        flush, flush_nxt;
   logic        enter_act;
   logic        ret_act;

   // The entry/return transfer happens on the edge that leaves IDLE/HANDLER;
   // ENTER and RETURN are the cycles that follow, while the flush is visible.
   assign enter_act = (state == IDLE) && bus.irq_in;
   assign ret_act   = (state == HANDLER) && bus.mret_in;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state    <= IDLE;
         pc       <= RESET_PC;
         epc      <= 64'h0;
         pend_pc  <= 64'h0;
         pend_vld <= 1'b0;
         pend_br  <= 1'b0;
         flush    <= 1'b0;
      end else begin
         state    <= state_nxt;
         pc       <= pc_nxt;
         epc      <= epc_nxt;
         pend_pc  <= pend_pc_nxt;
         pend_vld <= pend_vld_nxt;
         pend_br  <= pend_br_nxt;
         flush    <= flush_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      pc_nxt       = pc + PC_STEP;
      epc_nxt      = epc;
      pend_pc_nxt  = pend_pc;
      pend_vld_nxt = pend_vld;
      pend_br_nxt  = pend_br;
      flush_nxt    = 1'b0;

      case (state)
         IDLE:    if (enter_act) state_nxt = ENTER;
         ENTER:   state_nxt = HANDLER;
         HANDLER: if (ret_act) state_nxt = RETURN;
         RETURN:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase

      if (enter_act) begin
         epc_nxt      = pc;
         pc_nxt       = bus.irq_vector_in;
         flush_nxt    = 1'b1;
         pend_vld_nxt = 1'b0;
         pend_br_nxt  = 1'b0;
      end else if (ret_act) begin
         pc_nxt       = epc;
         flush_nxt    = 1'b1;
         pend_vld_nxt = 1'b0;
         pend_br_nxt  = 1'b0;
      end else if (bus.stall_in) begin
         pc_nxt = pc;
         // A resolved branch always wins the slot; a prediction never
         // displaces a captured branch.
         if (bus.branch_taken_in) begin
            pend_vld_nxt = 1'b1;
            pend_br_nxt  = 1'b1;
            pend_pc_nxt  = bus.branch_pc_in;
         end else if (bus.pred_taken_in && !(pend_vld && pend_br)) begin
            pend_vld_nxt = 1'b1;
            pend_br_nxt  = 1'b0;
            pend_pc_nxt  = bus.pred_pc_in;
         end
      end else if (bus.branch_taken_in) begin
         pc_nxt       = bus.branch_pc_in;
         flush_nxt    = 1'b1;
         pend_vld_nxt = 1'b0;
         pend_br_nxt  = 1'b0;
      end else if (pend_vld) begin
         pc_nxt       = pend_pc;
         flush_nxt    = 1'b1;
         pend_vld_nxt = 1'b0;
         pend_br_nxt  = 1'b0;
      end else if (bus.pred_taken_in) begin
         pc_nxt    = bus.pred_pc_in;
         flush_nxt = 1'b1;
      end
   end

   assign bus.pc_out            = pc;
   assign bus.instr_address_out = {2'b00, pc[63:2]};
   assign bus.epc_out           = epc;
   assign bus.in_handler_out    = (state == ENTER) || (state == HANDLER);
   assign bus.flush_out         = flush;

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Randomized self-checking bench for fetch_pc_sequencer with directed
// scenarios and a transaction-level reference model.
module tb_fetch_pc_sequencer;

   localparam logic [63:0] RESET_PC = 64'h0;
   localparam logic [63:0] PC_STEP  = 64'd4;

   logic clk_in = 1'b0;
   logic rst_n_in = 1'b0;
   always #5 clk_in = ~clk_in;

   fetch_pc_sequencer_if bus ();

   fetch_pc_sequencer #(.RESET_PC(RESET_PC), .PC_STEP(PC_STEP)) dut (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .bus      (bus)
   );

   typedef struct {
      bit          is_branch;
      logic [63:0] target;
   } redirect_t;

   // reference model
   logic [63:0] m_pc;
   logic [63:0] m_epc;
   bit          m_in_handler;
   bit          m_flush;
   bit          m_just_entered;
   bit          m_just_returned;
   redirect_t   m_pending[$];

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = RESET_PC;
      m_epc = 64'h0;
      m_in_handler = 0;
      m_flush = 0;
      m_just_entered = 0;
      m_just_returned = 0;
      m_pending.delete();
   endtask

   // What the next edge must do, given the inputs currently driven.
   task automatic model_step();
      redirect_t r;
      bit take_irq, take_ret;
      take_irq = !m_in_handler && !m_just_returned && (bus.irq_in === 1'b1);
      take_ret = m_in_handler && !m_just_entered && (bus.mret_in === 1'b1);
      m_flush = 0;
      m_just_entered = 0;
      m_just_returned = 0;
      if (take_irq) begin
         m_epc = m_pc;
         m_pc = bus.irq_vector_in;
         m_flush = 1;
         m_in_handler = 1;
         m_just_entered = 1;
         m_pending.delete();
      end else if (take_ret) begin
         m_pc = m_epc;
         m_flush = 1;
         m_in_handler = 0;
         m_just_returned = 1;
         m_pending.delete();
      end else if (bus.stall_in) begin
         if (bus.branch_taken_in) begin
            r.is_branch = 1; r.target = bus.branch_pc_in;
            m_pending.delete(); m_pending.push_back(r);
         end else if (bus.pred_taken_in) begin
            if (m_pending.size() == 0 || !m_pending[0].is_branch) begin
               r.is_branch = 0; r.target = bus.pred_pc_in;
               m_pending.delete(); m_pending.push_back(r);
            end
         end
      end else if (bus.branch_taken_in) begin
         m_pc = bus.branch_pc_in; m_flush = 1; m_pending.delete();
      end else if (m_pending.size() != 0) begin
         r = m_pending.pop_front();
         m_pc = r.target; m_flush = 1;
      end else if (bus.pred_taken_in) begin
         m_pc = bus.pred_pc_in; m_flush = 1;
      end else begin
         m_pc = m_pc + PC_STEP;
      end
   endtask

   task automatic check_all();
      chk("pc", bus.pc_out, m_pc);
      chk("iaddr", bus.instr_address_out, m_pc >> 2);
      chk("epc", bus.epc_out, m_epc);
      chk("in_handler", {63'h0, bus.in_handler_out}, {63'h0, m_in_handler});
      chk("flush", {63'h0, bus.flush_out}, {63'h0, m_flush});
   endtask

   task automatic drive(input bit st, input bit br, input logic [63:0] bpc,
                        input bit pr, input logic [63:0] ppc,
                        input bit irq, input logic [63:0] vec, input bit mret);
      bus.stall_in = st;
      bus.branch_taken_in = br;
      bus.branch_pc_in = bpc;
      bus.pred_taken_in = pr;
      bus.pred_pc_in = ppc;
      bus.irq_in = irq;
      bus.irq_vector_in = vec;
      bus.mret_in = mret;
   endtask

   // One clock: inputs already driven at a negedge; check at the next negedge.
   task automatic cyc();
      model_step();
      @(negedge clk_in);
      check_all();
   endtask

   task automatic idle_cyc();
      drive(0, 0, 64'h0, 0, 64'h0, 0, 64'h0, 0);
      cyc();
   endtask

   task automatic jump(input logic [63:0] t);
      drive(0, 1, t, 0, 64'h0, 0, 64'h0, 0);
      cyc();
   endtask

   function automatic logic [63:0] rnd64();
      logic [63:0] v;
      v = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) v = 64'hFFFF_FFFF_FFFF_FFF0 | {60'h0, v[3:0]};
      return v;
   endfunction

   initial begin
      drive(0, 0, 64'h0, 0, 64'h0, 0, 64'h0, 0);
      model_reset();
      repeat (2) @(negedge clk_in);
      check_all();
      chk("reset_pc", bus.pc_out, RESET_PC);
      rst_n_in = 1'b1;

      // sequential fetch from reset
      for (int i = 1; i <= 4; i++) begin
         idle_cyc();
         chk("seq_pc", bus.pc_out, 64'(i * 4));
         chk("seq_iaddr", bus.instr_address_out, 64'(i));
      end

      // branch beats prediction in the same cycle
      jump(64'h20);
      drive(0, 1, 64'h200, 1, 64'h100, 0, 64'h0, 0);
      cyc();
      chk("br_vs_pred_pc", bus.pc_out, 64'h200);
      chk("br_vs_pred_flush", {63'h0, bus.flush_out}, 64'h1);
      idle_cyc();
      chk("br_vs_pred_next", bus.pc_out, 64'h204);

      // pending slot: prediction then branch while stalled
      jump(64'h40);
      drive(1, 0, 64'h0, 1, 64'h80, 0, 64'h0, 0);
      cyc();
      chk("stall_hold1", bus.pc_out, 64'h40);
      drive(1, 1, 64'h90, 0, 64'h0, 0, 64'h0, 0);
      cyc();
      chk("stall_hold2", bus.pc_out, 64'h40);
      idle_cyc();
      chk("pend_apply", bus.pc_out, 64'h90);
      idle_cyc();
      chk("pend_next", bus.pc_out, 64'h94);

      // interrupt entry, no nesting, return
      jump(64'h50);
      drive(0, 0, 64'h0, 0, 64'h0, 1, 64'h1000, 0);
      cyc();
      chk("irq_pc", bus.pc_out, 64'h1000);
      chk("irq_epc", bus.epc_out, 64'h50);
      chk("irq_inh", {63'h0, bus.in_handler_out}, 64'h1);
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 64'h0, 0, 64'h0, 1, 64'h2000, 0);
         cyc();
      end
      chk("no_nest_epc", bus.epc_out, 64'h50);
      drive(0, 0, 64'h0, 0, 64'h0, 0, 64'h0, 1);
      cyc();
      chk("mret_pc", bus.pc_out, 64'h50);
      chk("mret_inh", {63'h0, bus.in_handler_out}, 64'h0);
      idle_cyc();

      // 64-bit wrap
      jump(64'hFFFF_FFFF_FFFF_FFFC);
      idle_cyc();
      chk("wrap_pc", bus.pc_out, 64'h0);
      chk("wrap_iaddr", bus.instr_address_out, 64'h0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(0, 99) < 30,
               $urandom_range(0, 99) < 15, rnd64(),
               $urandom_range(0, 99) < 20, rnd64(),
               $urandom_range(0, 99) < 6, rnd64(),
               $urandom_range(0, 99) < 15);
         cyc();
      end

      // asynchronous reset while in the handler
      drive(0, 0, 64'h0, 0, 64'h0, 1, 64'h3000, 0);
      cyc();
      drive(0, 0, 64'h0, 0, 64'h0, 0, 64'h0, 0);
      cyc();
      cyc();
      chk("pre_rst_inh", {63'h0, bus.in_handler_out}, {63'h0, m_in_handler});
      #2;
      rst_n_in = 1'b0;
      #1;
      model_reset();
      check_all();
      chk("async_rst_pc", bus.pc_out, RESET_PC);
      chk("async_rst_inh", {63'h0, bus.in_handler_out}, 64'h0);
      @(negedge clk_in);
      rst_n_in = 1'b1;
      for (int i = 0; i < 3; i++) idle_cyc();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
